// File: rtl/filter_loader.sv
// Write sequencer for the filter SRAM: turns a valid/ready stream of sparse beats into
// SRAM write strobes with beat/chunk indices, loading chunk_num chunks from chunk_base.
module filter_loader #(
  parameter int BUS_SIZE         = 32,
  parameter int MEM_SIZE         = 128,
  parameter int CHANNEL_NUM      = 32,
  parameter int COMPUTE_UNIT_NUM = 2,
  localparam int DAT_CYC_NUM     = MEM_SIZE / BUS_SIZE,
  localparam int FILTER_NUM      = (MEM_SIZE / CHANNEL_NUM) * COMPUTE_UNIT_NUM,
  localparam int DW              = $clog2(DAT_CYC_NUM),
  localparam int CW              = $clog2(FILTER_NUM)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [CW-1:0]            chunk_base_i,
  input  logic [CW:0]              chunk_num_i,
  input  logic [BUS_SIZE-1:0]      in_sparsemap_i,
  input  logic [BUS_SIZE-1:0][7:0] in_nonzero_data_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  output logic [BUS_SIZE-1:0]      wr_sparsemap_o,
  output logic [BUS_SIZE-1:0][7:0] wr_nonzero_data_o,
  output logic                     wr_valid_o,
  output logic [DW-1:0]            wr_dat_count_o,
  output logic [CW-1:0]            wr_chunk_count_o,
  output logic                     busy_o,
  output logic                     done_o
);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

  state_t        state;
  logic [DW-1:0] dat_cnt;
  logic [CW-1:0] chunk_cnt;
  logic [CW:0]   chunks_left;
  logic          accept;
  logic          last_beat;

  // in_ready_o is only ever high in LOAD, so no state qualifier is needed here.
  assign accept    = in_valid_i & in_ready_o;
  assign last_beat = (dat_cnt == DW'(DAT_CYC_NUM - 1)) && (chunks_left == (CW + 1)'(1));

  // NOTE: all state here is sequential, so every assignment uses <=; blocking assignments
  // in a clocked block would make results depend on statement order and simulator scheduling.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state             <= IDLE;
      dat_cnt           <= '0;
      chunk_cnt         <= '0;
      chunks_left       <= '0;
      in_ready_o        <= 1'b0;
      wr_sparsemap_o    <= '0;
      wr_nonzero_data_o <= '0;
      wr_valid_o        <= 1'b0;
      wr_dat_count_o    <= '0;
      wr_chunk_count_o  <= '0;
      busy_o            <= 1'b0;
      done_o            <= 1'b0;
    end else begin
      wr_valid_o <= accept;
      done_o     <= 1'b0;

      if (accept) begin
        wr_sparsemap_o    <= in_sparsemap_i;
        wr_nonzero_data_o <= in_nonzero_data_i;
        wr_dat_count_o    <= dat_cnt;
        wr_chunk_count_o  <= chunk_cnt;
        if (dat_cnt == DW'(DAT_CYC_NUM - 1)) begin
          dat_cnt     <= '0;
          chunk_cnt   <= (chunk_cnt == CW'(FILTER_NUM - 1)) ? '0 : chunk_cnt + 1'b1;
          chunks_left <= chunks_left - 1'b1;
        end else begin
          dat_cnt <= dat_cnt + 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (start_i) begin
            busy_o    <= 1'b1;
            dat_cnt   <= '0;
            chunk_cnt <= chunk_base_i;
            if (chunk_num_i == '0) begin
              state  <= DONE;
              done_o <= 1'b1;
            end else begin
              chunks_left <= (chunk_num_i > (CW + 1)'(FILTER_NUM)) ? (CW + 1)'(FILTER_NUM)
                                                                   : chunk_num_i;
              in_ready_o  <= 1'b1;
              state       <= LOAD;
            end
          end
        end
        LOAD: begin
          if (accept && last_beat) begin
            in_ready_o <= 1'b0;
            state      <= FLUSH;
          end
        end
        FLUSH: begin
          state  <= DONE;
          done_o <= 1'b1;
        end
        DONE: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_filter_loader.sv
// Directed bench for filter_loader (BUS_SIZE=32, MEM_SIZE=128 -> 4 beats/chunk, 8 chunks).
module tb_filter_loader;

  localparam int BUS = 32;
  localparam int DAT_CYC = 4;
  localparam int FNUM = 8;

  logic               clk_i = 1'b0;
  logic               rst_i = 1'b1;
  logic               start_i = 1'b0;
  logic [2:0]         chunk_base_i = '0;
  logic [3:0]         chunk_num_i = '0;
  logic [BUS-1:0]     in_sparsemap_i = '0;
  logic [BUS-1:0][7:0] in_nonzero_data_i = '0;
  logic               in_valid_i = 1'b0;
  logic               in_ready_o;
  logic [BUS-1:0]     wr_sparsemap_o;
  logic [BUS-1:0][7:0] wr_nonzero_data_o;
  logic               wr_valid_o;
  logic [1:0]         wr_dat_count_o;
  logic [2:0]         wr_chunk_count_o;
  logic               busy_o;
  logic               done_o;

  int n_cmp = 0;
  int n_mis = 0;
  int tag = 0;

  filter_loader #(
    .BUS_SIZE(32), .MEM_SIZE(128), .CHANNEL_NUM(32), .COMPUTE_UNIT_NUM(2)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .chunk_base_i(chunk_base_i), .chunk_num_i(chunk_num_i),
    .in_sparsemap_i(in_sparsemap_i), .in_nonzero_data_i(in_nonzero_data_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .wr_sparsemap_o(wr_sparsemap_o), .wr_nonzero_data_o(wr_nonzero_data_o),
    .wr_valid_o(wr_valid_o), .wr_dat_count_o(wr_dat_count_o),
    .wr_chunk_count_o(wr_chunk_count_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [BUS-1:0] smap(input int k);
    return 32'h5A00_0000 | 32'(tag << 16) | 32'(k);
  endfunction

  function automatic logic [BUS*8-1:0] bdata(input int k);
    return {8{8'(k), 8'(tag), 8'h3C, ~8'(k)}};
  endfunction

  // Starts a load, streams n_exp beats (optionally with bubbles and a stray start), then
  // checks the FLUSH/DONE tail. Expected indices come from k: dat=k%4, chunk=(base+k/4)%8.
  task automatic run_load(input string name, input int base, input int num, input int n_exp,
                          input bit gaps, input bit poke);
    int k = 0;
    int cyc = 0;
    bit v;
    tag++;
    chunk_base_i = 3'(base); chunk_num_i = 4'(num); start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0; chunk_base_i = '0; chunk_num_i = '0;
    n_cmp++; if (busy_o !== 1'b1) begin n_mis++; $display("FAIL %s busy_after_start got %b want 1", name, busy_o); end
    while (k < n_exp && cyc < 400) begin
      n_cmp++; if (in_ready_o !== 1'b1) begin n_mis++; $display("FAIL %s ready k=%0d got %b want 1", name, k, in_ready_o); end
      v = gaps ? (((cyc * 7) % 5) < 3) : 1'b1;
      in_valid_i = v; in_sparsemap_i = smap(k); in_nonzero_data_i = bdata(k);
      if (poke && k == 2) begin start_i = 1'b1; chunk_base_i = 3'd5; chunk_num_i = 4'd3; end
      @(negedge clk_i);
      start_i = 1'b0; chunk_base_i = '0; chunk_num_i = '0;
      if (v) begin
        n_cmp++; if (wr_valid_o !== 1'b1) begin n_mis++; $display("FAIL %s wr_valid k=%0d got %b want 1", name, k, wr_valid_o); end
        n_cmp++; if (wr_dat_count_o !== 2'(k % DAT_CYC)) begin n_mis++; $display("FAIL %s dat k=%0d got %0d want %0d", name, k, wr_dat_count_o, k % DAT_CYC); end
        n_cmp++; if (wr_chunk_count_o !== 3'((base + k / DAT_CYC) % FNUM)) begin n_mis++; $display("FAIL %s chunk k=%0d got %0d want %0d", name, k, wr_chunk_count_o, (base + k / DAT_CYC) % FNUM); end
        n_cmp++; if (wr_sparsemap_o !== smap(k)) begin n_mis++; $display("FAIL %s smap k=%0d got %h want %h", name, k, wr_sparsemap_o, smap(k)); end
        n_cmp++; if (wr_nonzero_data_o !== bdata(k)) begin n_mis++; $display("FAIL %s data k=%0d got %h want %h", name, k, wr_nonzero_data_o, bdata(k)); end
        k++;
      end else begin
        n_cmp++; if (wr_valid_o !== 1'b0) begin n_mis++; $display("FAIL %s wr_valid_bubble k=%0d got %b want 0", name, k, wr_valid_o); end
      end
      cyc++;
    end
    if (k < n_exp) begin
      n_cmp++; n_mis++;
      $display("FAIL %s timeout writes got %0d want %0d", name, k, n_exp);
    end
    // FLUSH: a beat is still offered but must not be taken.
    in_valid_i = 1'b1; in_sparsemap_i = 32'hDEAD_BEEF; in_nonzero_data_i = '1;
    n_cmp++; if (in_ready_o !== 1'b0) begin n_mis++; $display("FAIL %s ready_flush got %b want 0", name, in_ready_o); end
    n_cmp++; if (done_o !== 1'b0) begin n_mis++; $display("FAIL %s done_early got %b want 0", name, done_o); end
    @(negedge clk_i);
    n_cmp++; if (done_o !== 1'b1) begin n_mis++; $display("FAIL %s done_pulse got %b want 1", name, done_o); end
    n_cmp++; if (wr_valid_o !== 1'b0) begin n_mis++; $display("FAIL %s wr_valid_done got %b want 0", name, wr_valid_o); end
    n_cmp++; if (busy_o !== 1'b1) begin n_mis++; $display("FAIL %s busy_done got %b want 1", name, busy_o); end
    n_cmp++; if (wr_sparsemap_o !== smap(n_exp - 1)) begin n_mis++; $display("FAIL %s smap_hold got %h want %h", name, wr_sparsemap_o, smap(n_exp - 1)); end
    in_valid_i = 1'b0;
    @(negedge clk_i);
    n_cmp++; if (done_o !== 1'b0) begin n_mis++; $display("FAIL %s done_width got %b want 0", name, done_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_mis++; $display("FAIL %s busy_idle got %b want 0", name, busy_o); end
  endtask

  task automatic check_all_zero(input string name);
    n_cmp++; if (wr_valid_o !== 1'b0) begin n_mis++; $display("FAIL %s wr_valid got %b want 0", name, wr_valid_o); end
    n_cmp++; if (in_ready_o !== 1'b0) begin n_mis++; $display("FAIL %s in_ready got %b want 0", name, in_ready_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_mis++; $display("FAIL %s busy got %b want 0", name, busy_o); end
    n_cmp++; if (done_o !== 1'b0) begin n_mis++; $display("FAIL %s done got %b want 0", name, done_o); end
    n_cmp++; if (wr_dat_count_o !== 2'd0) begin n_mis++; $display("FAIL %s dat got %0d want 0", name, wr_dat_count_o); end
    n_cmp++; if (wr_chunk_count_o !== 3'd0) begin n_mis++; $display("FAIL %s chunk got %0d want 0", name, wr_chunk_count_o); end
    n_cmp++; if (wr_sparsemap_o !== '0) begin n_mis++; $display("FAIL %s smap got %h want 0", name, wr_sparsemap_o); end
    n_cmp++; if (wr_nonzero_data_o !== '0) begin n_mis++; $display("FAIL %s data got %h want 0", name, wr_nonzero_data_o); end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    check_all_zero("reset");
    rst_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_single_chunk();
    run_load("single", 0, 1, 4, 1'b0, 1'b0);
  endtask

  task automatic test_wrap();
    run_load("wrap", 6, 3, 12, 1'b0, 1'b0);
  endtask

  task automatic test_gaps();
    run_load("gaps", 2, 2, 8, 1'b1, 1'b0);
  endtask

  task automatic test_zero_and_saturate();
    chunk_base_i = 3'd4; chunk_num_i = 4'd0; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    n_cmp++; if (done_o !== 1'b1) begin n_mis++; $display("FAIL zero done got %b want 1", done_o); end
    n_cmp++; if (wr_valid_o !== 1'b0) begin n_mis++; $display("FAIL zero wr_valid got %b want 0", wr_valid_o); end
    n_cmp++; if (in_ready_o !== 1'b0) begin n_mis++; $display("FAIL zero in_ready got %b want 0", in_ready_o); end
    @(negedge clk_i);
    n_cmp++; if (done_o !== 1'b0) begin n_mis++; $display("FAIL zero done_width got %b want 0", done_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_mis++; $display("FAIL zero busy got %b want 0", busy_o); end
    run_load("saturate", 4, 9, 32, 1'b0, 1'b0);
  endtask

  task automatic test_ignore_start_and_idle_beats();
    run_load("poke", 1, 1, 4, 1'b0, 1'b1);
    in_valid_i = 1'b1; in_sparsemap_i = 32'h0BAD_0BAD;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      n_cmp++; if (in_ready_o !== 1'b0) begin n_mis++; $display("FAIL idle_ready cyc=%0d got %b want 0", i, in_ready_o); end
      n_cmp++; if (wr_valid_o !== 1'b0) begin n_mis++; $display("FAIL idle_wr_valid cyc=%0d got %b want 0", i, wr_valid_o); end
    end
    in_valid_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_reset_mid_load();
    chunk_base_i = 3'd1; chunk_num_i = 4'd2; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid_i = 1'b1; in_sparsemap_i = 32'(i + 1); in_nonzero_data_i = '1;
      @(negedge clk_i);
    end
    in_valid_i = 1'b0; rst_i = 1'b1;
    @(negedge clk_i);
    check_all_zero("mid_reset");
    rst_i = 1'b0;
    @(negedge clk_i);
    run_load("after_reset", 3, 1, 4, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single_chunk();
    test_wrap();
    test_gaps();
    test_zero_and_saturate();
    test_ignore_start_and_idle_beats();
    test_reset_mid_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
